// File: rtl/pong_pkg.sv
// Shared constants for the pong match controller: state codes and winner codes.
package pong_pkg;

  // Match state codes; this is also the encoding driven on dstate.
  localparam logic [2:0] ST_MENU      = 3'd0;
  localparam logic [2:0] ST_SET       = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_PLAY      = 3'd3;
  localparam logic [2:0] ST_END_POINT = 3'd4;
  localparam logic [2:0] ST_END_GAME  = 3'd5;
  localparam logic [2:0] ST_PAUSE     = 3'd6;

  // Winner codes.
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b01;
  localparam logic [1:0] WIN_R    = 2'b10;

endpackage

// File: rtl/pong_edge_sync.sv
// Synchroniser for one asynchronous level input, followed by a registered
// rise/fall detector. Each output pulses for one cycle per synchronised edge.
module pong_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   sync_lvl;

  // Fully synchronised level; the earlier stages are never looked at by logic.
  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Shift the raw level through the synchroniser and register the edge strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_lvl;
      rise_q <= sync_lvl & ~prev_q;
      fall_q <= ~sync_lvl & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/pong_match_fsm.sv
// Pong match controller: menu/serve/play/pause sequencing, point hold timer,
// per-player scores, serve side and winner. All outputs come straight from flops.
module pong_match_fsm
  import pong_pkg::*;
#(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int POINT_HOLD  = 50,
  parameter int HOLD_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_f,
  input  logic               reset,
  input  logic               launch,
  input  logic               pause,
  input  logic               left_hit,
  input  logic               right_hit,
  output logic [2:0]         dstate,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               serve_left,
  output logic [1:0]         winner,
  output logic               ball_en,
  output logic               point_pulse
);

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(POINT_HOLD - 1);

  // Conditioned edge strobes.
  logic launch_rise, launch_fall;
  logic pause_rise, pause_fall_unused;
  logic lhit_rise, lhit_fall_unused;
  logic rhit_rise, rhit_fall_unused;

  pong_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_launch (
    .clk_i(clk_f), .rst_i(reset), .async_i(launch),
    .rise_o(launch_rise), .fall_o(launch_fall)
  );

  pong_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pause (
    .clk_i(clk_f), .rst_i(reset), .async_i(pause),
    .rise_o(pause_rise), .fall_o(pause_fall_unused)
  );

  pong_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lhit (
    .clk_i(clk_f), .rst_i(reset), .async_i(left_hit),
    .rise_o(lhit_rise), .fall_o(lhit_fall_unused)
  );

  pong_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rhit (
    .clk_i(clk_f), .rst_i(reset), .async_i(right_hit),
    .rise_o(rhit_rise), .fall_o(rhit_fall_unused)
  );

  logic [2:0]         state_q, state_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               serve_q, serve_d;
  logic [1:0]         winner_q, winner_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               pulse_q, pulse_d;
  logic               ball_en_q;

  // Scores stop at the winning value and never wrap.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v >= WIN_VAL) ? v : v + SCORE_W'(1);
  endfunction

  // Next-state, score, serve, winner and hold-timer decisions.
  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    serve_d   = serve_q;
    winner_d  = winner_q;
    hold_d    = hold_q;
    pulse_d   = 1'b0;
    case (state_q)
      ST_MENU: begin
        if (launch_fall) begin
          state_d   = ST_SET;
          score_l_d = '0;
          score_r_d = '0;
          serve_d   = 1'b1;
          winner_d  = WIN_NONE;
        end
      end
      ST_SET: begin
        if (launch_fall) state_d = ST_START;
      end
      ST_START: begin
        if (launch_rise) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (pause_rise) begin
          state_d = ST_PAUSE;
        end else if (lhit_rise && rhit_rise) begin
          // Simultaneous wall hits: replay the point with no score change.
          state_d = ST_END_POINT;
          hold_d  = '0;
        end else if (lhit_rise) begin
          state_d   = ST_END_POINT;
          hold_d    = '0;
          score_r_d = sat_inc(score_r_q);
          serve_d   = 1'b0;
          pulse_d   = 1'b1;
        end else if (rhit_rise) begin
          state_d   = ST_END_POINT;
          hold_d    = '0;
          score_l_d = sat_inc(score_l_q);
          serve_d   = 1'b1;
          pulse_d   = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (pause_rise) state_d = ST_PLAY;
      end
      ST_END_POINT: begin
        if (hold_q == HOLD_LAST) begin
          if (score_l_q == WIN_VAL || score_r_q == WIN_VAL) begin
            state_d  = ST_END_GAME;
            winner_d = (score_l_q == WIN_VAL) ? WIN_L : WIN_R;
          end else begin
            state_d = ST_START;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_END_GAME: begin
        if (launch_fall) state_d = ST_MENU;
      end
      default: state_d = ST_MENU;
    endcase
  end

  // Commit the decisions; ball_en is registered alongside the state it mirrors.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state_q   <= ST_MENU;
      score_l_q <= '0;
      score_r_q <= '0;
      serve_q   <= 1'b1;
      winner_q  <= WIN_NONE;
      hold_q    <= '0;
      pulse_q   <= 1'b0;
      ball_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      serve_q   <= serve_d;
      winner_q  <= winner_d;
      hold_q    <= hold_d;
      pulse_q   <= pulse_d;
      ball_en_q <= (state_d == ST_PLAY);
    end
  end

  assign dstate      = state_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign serve_left  = serve_q;
  assign winner      = winner_q;
  assign ball_en     = ball_en_q;
  assign point_pulse = pulse_q;

endmodule

// File: tb/tb_pong_match_fsm.sv
// Bench for pong_match_fsm: directed scenarios with literal expectations plus
// randomized stimulus, all compared every cycle against a behavioural model.
module tb_pong_match_fsm;

  localparam int SW  = 4;
  localparam int WIN = 2;
  localparam int PH  = 4;
  localparam int HW  = 3;
  localparam int SS  = 2;

  // State numbers as listed in the design description.
  localparam int MENU = 0, SET = 1, START = 2, PLAY = 3, EP = 4, EG = 5, PAUSE = 6;

  logic          clk_f = 1'b0;
  logic          reset;
  logic          launch, pause, left_hit, right_hit;
  logic [2:0]    dstate;
  logic [SW-1:0] score_l, score_r;
  logic          serve_left;
  logic [1:0]    winner;
  logic          ball_en, point_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  pong_match_fsm #(
    .SCORE_W(SW), .WIN_SCORE(WIN), .POINT_HOLD(PH), .HOLD_W(HW), .SYNC_STAGES(SS)
  ) dut (
    .clk_f(clk_f), .reset(reset), .launch(launch), .pause(pause),
    .left_hit(left_hit), .right_hit(right_hit), .dstate(dstate),
    .score_l(score_l), .score_r(score_r), .serve_left(serve_left),
    .winner(winner), .ball_en(ball_en), .point_pulse(point_pulse)
  );

  // Clock
  always #5 clk_f = ~clk_f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw input samples, oldest first; an input edge reaches the match logic
  // SS+1 clock edges after the edge that first samples it.
  bit h_la[$], h_pa[$], h_lh[$], h_rh[$];
  int m_state, m_sl, m_sr, m_serve, m_win, m_ep_cycles, m_pulse;

  function automatic void model_reset();
    h_la.delete(); h_pa.delete(); h_lh.delete(); h_rh.delete();
    for (int i = 0; i < SS + 2; i++) begin
      h_la.push_back(1'b0); h_pa.push_back(1'b0);
      h_lh.push_back(1'b0); h_rh.push_back(1'b0);
    end
    m_state = MENU; m_sl = 0; m_sr = 0; m_serve = 1; m_win = 0;
    m_ep_cycles = 0; m_pulse = 0;
  endfunction

  function automatic void model_step();
    bit l_rise, l_fall, p_rise, lh_rise, rh_rise;
    l_rise  = h_la[1] && !h_la[0];
    l_fall  = !h_la[1] && h_la[0];
    p_rise  = h_pa[1] && !h_pa[0];
    lh_rise = h_lh[1] && !h_lh[0];
    rh_rise = h_rh[1] && !h_rh[0];
    void'(h_la.pop_front()); h_la.push_back(launch);
    void'(h_pa.pop_front()); h_pa.push_back(pause);
    void'(h_lh.pop_front()); h_lh.push_back(left_hit);
    void'(h_rh.pop_front()); h_rh.push_back(right_hit);
    m_pulse = 0;
    case (m_state)
      MENU: if (l_fall) begin
        m_state = SET; m_sl = 0; m_sr = 0; m_win = 0; m_serve = 1;
      end
      SET:   if (l_fall) m_state = START;
      START: if (l_rise) m_state = PLAY;
      PLAY: begin
        if (p_rise) m_state = PAUSE;
        else if (lh_rise || rh_rise) begin
          m_state = EP; m_ep_cycles = 1;
          if (lh_rise && !rh_rise) begin
            m_sr = (m_sr < WIN) ? m_sr + 1 : m_sr; m_serve = 0; m_pulse = 1;
          end else if (rh_rise && !lh_rise) begin
            m_sl = (m_sl < WIN) ? m_sl + 1 : m_sl; m_serve = 1; m_pulse = 1;
          end
        end
      end
      PAUSE: if (p_rise) m_state = PLAY;
      EP: begin
        if (m_ep_cycles == PH) begin
          if (m_sl == WIN || m_sr == WIN) begin
            m_state = EG; m_win = (m_sl == WIN) ? 1 : 2;
          end else m_state = START;
        end else m_ep_cycles++;
      end
      EG: if (l_fall) m_state = MENU;
      default: m_state = MENU;
    endcase
  endfunction

  // Compare process: advance the model on each rising edge, check on the falling edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk_f);
      if (reset) model_reset(); else model_step();
      @(negedge clk_f);
      if (reset) model_reset();
      check("model_dstate", 32'(dstate), 32'(m_state));
      check("model_score_l", 32'(score_l), 32'(m_sl));
      check("model_score_r", 32'(score_r), 32'(m_sr));
      check("model_serve_left", 32'(serve_left), 32'(m_serve));
      check("model_winner", 32'(winner), 32'(m_win));
      check("model_ball_en", 32'(ball_en), 32'(m_state == PLAY));
      check("model_point_pulse", 32'(point_pulse), 32'(m_pulse));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk_f);
    #1;
  endtask

  // From SET or START with launch held high: walk into PLAY.
  task automatic go_play();
    launch = 1'b0; step(5);
    launch = 1'b1; step(4);
    check("go_play_dstate", 32'(dstate), 32'(PLAY));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; launch = 1'b0; pause = 1'b0; left_hit = 1'b0; right_hit = 1'b0;
    step(3);
    check("rst_dstate", 32'(dstate), 0);
    check("rst_scores", 32'({score_l, score_r}), 0);
    check("rst_serve", 32'(serve_left), 1);
    check("rst_winner", 32'(winner), 0);
    check("rst_ball_en", 32'(ball_en), 0);
    check("rst_pulse", 32'(point_pulse), 0);
    reset = 1'b0;

    // 1: launch press/release twice, then press.
    launch = 1'b1; step(5);
    check("menu_ignores_rise", 32'(dstate), 0);
    launch = 1'b0; step(3);
    check("latency_not_yet", 32'(dstate), 0);
    step(1);
    check("menu_to_set", 32'(dstate), 1);
    launch = 1'b1; step(5);
    launch = 1'b0; step(4);
    check("set_to_start", 32'(dstate), 2);
    launch = 1'b1; step(4);
    check("start_to_play", 32'(dstate), 3);
    check("play_ball_en", 32'(ball_en), 1);
    check("play_scores", 32'({score_l, score_r}), 0);

    // 2: right wall hit scores for left.
    right_hit = 1'b1; step(4);
    check("rhit_dstate", 32'(dstate), 4);
    check("rhit_pulse", 32'(point_pulse), 1);
    check("rhit_score_l", 32'(score_l), 1);
    check("rhit_serve", 32'(serve_left), 1);
    right_hit = 1'b0; step(1);
    check("pulse_one_cycle", 32'(point_pulse), 0);
    check("hold_c2", 32'(dstate), 4);
    step(2);
    check("hold_c4", 32'(dstate), 4);
    step(1);
    check("hold_exit_start", 32'(dstate), 2);

    // 4: simultaneous hits.
    go_play();
    left_hit = 1'b1; right_hit = 1'b1; step(4);
    check("both_dstate", 32'(dstate), 4);
    check("both_pulse", 32'(point_pulse), 0);
    check("both_scores", 32'({score_l, score_r}), 32'({4'd1, 4'd0}));
    check("both_serve", 32'(serve_left), 1);
    left_hit = 1'b0; right_hit = 1'b0; step(4);
    check("both_exit_start", 32'(dstate), 2);

    // 5: pause, ignored hit, resume.
    go_play();
    pause = 1'b1; step(4);
    check("pause_dstate", 32'(dstate), 6);
    check("pause_ball_en", 32'(ball_en), 0);
    pause = 1'b0; step(2);
    left_hit = 1'b1; step(6);
    check("pause_hit_ignored", 32'(dstate), 6);
    check("pause_score_r", 32'(score_r), 0);
    left_hit = 1'b0; step(2);
    pause = 1'b1; step(4);
    check("resume_dstate", 32'(dstate), 3);
    pause = 1'b0; step(6);
    check("resume_no_late_hit", 32'(dstate), 3);

    // 3: right player wins to WIN=2.
    left_hit = 1'b1; step(4);
    check("lhit_score_r", 32'(score_r), 1);
    check("lhit_serve", 32'(serve_left), 0);
    left_hit = 1'b0; step(4);
    check("lhit_exit_start", 32'(dstate), 2);
    go_play();
    left_hit = 1'b1; step(4);
    check("win_score_r", 32'(score_r), 2);
    check("win_ep", 32'(dstate), 4);
    step(4);
    check("end_game", 32'(dstate), 5);
    check("winner_right", 32'(winner), 2);
    left_hit = 1'b0; launch = 1'b0; step(4);
    check("eg_to_menu", 32'(dstate), 0);
    check("menu_keeps_winner", 32'(winner), 2);
    launch = 1'b1; step(5);
    launch = 1'b0; step(4);
    check("clear_dstate", 32'(dstate), 1);
    check("clear_winner", 32'(winner), 0);
    check("clear_scores", 32'({score_l, score_r}), 0);
    check("clear_serve", 32'(serve_left), 1);

    // 6: reset in the middle of END_POINT.
    launch = 1'b1; step(5);
    go_play();
    right_hit = 1'b1; step(5);
    check("pre_rst_ep", 32'(dstate), 4);
    check("pre_rst_score_l", 32'(score_l), 1);
    reset = 1'b1; #1;
    check("async_rst_dstate", 32'(dstate), 0);
    check("async_rst_scores", 32'({score_l, score_r}), 0);
    check("async_rst_winner", 32'(winner), 0);
    check("async_rst_serve", 32'(serve_left), 1);
    check("async_rst_ball_en", 32'(ball_en), 0);
    right_hit = 1'b0; launch = 1'b0;
    step(2);
    reset = 1'b0;

    // Random phase: level inputs toggle at random, occasional reset pulses.
    for (int i = 0; i < 4000; i++) begin
      step(1);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 699) == 0) reset = 1'b1;
      if ($urandom_range(0, 5) == 0) launch = ~launch;
      if ($urandom_range(0, 24) == 0) pause = ~pause;
      if ($urandom_range(0, 6) == 0) left_hit = ~left_hit;
      if ($urandom_range(0, 6) == 0) right_hit = ~right_hit;
      if ($urandom_range(0, 49) == 0) begin
        left_hit = ~left_hit; right_hit = left_hit;
      end
    end
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
